// File: rtl/lsu_mem_stage_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage_if
// Data-memory bus between the load/store stage and the data memory.
// The bus uses a valid/ready handshake. The master holds mem_req and every
// request field stable until the slave raises mem_ready for one cycle.
//   mem_req    master -> slave  access request
//   mem_we     master -> slave  1 = write, 0 = read
//   mem_addr   master -> slave  word-aligned byte address
//   mem_be     master -> slave  byte-lane enables
//   mem_wdata  master -> slave  lane-aligned store data
//   mem_ready  slave  -> master access accepted/completed this cycle
//   mem_rdata  slave  -> master read word, valid with mem_ready
// -----------------------------------------------------------------------------
interface lsu_mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_be,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_be,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// This is the memory-access stage, placed after the execute stage. It performs
// RISC-V byte, half and word loads and stores over the data bus. It holds the
// pipeline with stall while an access is outstanding. It also presents a
// registered write-back bundle with an exception code.
//
// Ports
//   clk, rst       clock and synchronous active-high reset
//   ex_*           instruction bundle from the execute stage
//   flush          kills the instruction presented this cycle
//   stall          upstream must hold its outputs (state is WAIT)
//   bus            data-memory bus (master side)
//   wb_valid       one-cycle pulse per accepted instruction
//   wb_regw/rd     register-file write enable and destination
//   wb_data        write-back value
//   wb_exc         00 none, 01 misaligned, 10 timeout, 11 illegal
//
// Parameter
//   MAX_WAIT       Number of cycles with mem_ready low that the stage waits
//                  before it aborts the access (1..255).
// -----------------------------------------------------------------------------
module lsu_mem_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  input  logic                   flush,
  input  logic                   ex_memr,
  input  logic                   ex_memw,
  input  logic                   ex_mem2reg,
  input  logic                   ex_regw,
  input  logic [2:0]             ex_funct3,
  input  logic [31:0]            ex_alu_result,
  input  logic [31:0]            ex_rs2_data,
  input  logic [4:0]             ex_rd,
  output logic                   stall,
  lsu_mem_stage_if.master        bus,
  output logic                   wb_valid,
  output logic                   wb_regw,
  output logic [4:0]             wb_rd,
  output logic [31:0]            wb_data,
  output logic [1:0]             wb_exc
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

  // The last WAIT cycle that is allowed before the access is aborted.
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  logic [0:0]  state_r;
  logic [7:0]  wait_cnt_r;

  // These fields are captured when the access starts. The completion cycle
  // needs them, and by then the execute stage may have moved on.
  logic        cap_load_r;
  logic        cap_regw_r;
  logic        cap_mem2reg_r;
  logic [2:0]  cap_funct3_r;
  logic [1:0]  cap_lane_r;
  logic [31:0] cap_alu_r;
  logic [4:0]  cap_rd_r;

  logic        accept_s;
  logic        is_mem_s;
  logic        illegal_s;
  logic        misalign_s;
  logic [31:0] load_data_s;

  // A load may use only LB/LH/LW/LBU/LHU. A store may use only SB/SH/SW.
  // An op cannot be both a load and a store.
  function automatic logic is_illegal(input logic memr, input logic memw,
                                      input logic [2:0] funct3);
    logic bad;
    if (memr && memw) begin
      bad = 1'b1;
    end else if (memr) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad = 1'b0;
        default:                                bad = 1'b1;
      endcase
    end else if (memw) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: bad = 1'b0;
        default:                bad = 1'b1;
      endcase
    end else begin
      bad = 1'b0;
    end
    return bad;
  endfunction

  // funct3[1:0] gives the access size. 00 is a byte, 01 a half, 10 a word.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] lane);
    logic bad;
    case (funct3[1:0])
      2'b01:   bad = lane[0];
      2'b10:   bad = (lane != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] funct3,
                                              input logic [1:0] lane);
    logic [3:0] be;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // The store data is replicated across all lanes. The memory then picks the
  // correct lane using only the byte enables.
  function automatic logic [31:0] store_data(input logic [2:0] funct3,
                                             input logic [31:0] rs2);
    logic [31:0] wdata;
    case (funct3[1:0])
      2'b00:   wdata = {4{rs2[7:0]}};
      2'b01:   wdata = {2{rs2[15:0]}};
      2'b10:   wdata = rs2;
      default: wdata = 32'h0000_0000;
    endcase
    return wdata;
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] funct3,
                                               input logic [1:0] lane);
    logic [31:0] shifted;
    logic [31:0] result;
    shifted = word >> {lane, 3'b000};
    case (funct3)
      3'b000:  result = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  result = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  result = word;
      3'b100:  result = {24'h00_0000, shifted[7:0]};
      3'b101:  result = {16'h0000, shifted[15:0]};
      default: result = 32'h0000_0000;
    endcase
    return result;
  endfunction

  // Decode the instruction presented in IDLE, and align the returned read data.
  always_comb begin
    accept_s    = ex_valid & ~flush;
    is_mem_s    = ex_memr | ex_memw;
    illegal_s   = is_illegal(ex_memr, ex_memw, ex_funct3);
    misalign_s  = is_misaligned(ex_funct3, ex_alu_result[1:0]);
    load_data_s = load_extract(bus.mem_rdata, cap_funct3_r, cap_lane_r);
  end

  // The pipeline is held for the whole time an access is outstanding.
  always_comb begin
    stall = (state_r == ST_WAIT);
  end

  // Control FSM, bus request registers, captured op and write-back bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= 8'd0;
      cap_load_r    <= 1'b0;
      cap_regw_r    <= 1'b0;
      cap_mem2reg_r <= 1'b0;
      cap_funct3_r  <= 3'b000;
      cap_lane_r    <= 2'b00;
      cap_alu_r     <= 32'h0000_0000;
      cap_rd_r      <= 5'd0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0000_0000;
      bus.mem_be    <= 4'b0000;
      bus.mem_wdata <= 32'h0000_0000;
      wb_valid      <= 1'b0;
      wb_regw       <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= 32'h0000_0000;
      wb_exc        <= EXC_NONE;
    end else begin
      // The write-back bundle is a single-cycle pulse. It is quiet unless a
      // branch below fires it.
      wb_valid <= 1'b0;
      wb_regw  <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'h0000_0000;
      wb_exc   <= EXC_NONE;

      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (!is_mem_s) begin
              wb_valid <= 1'b1;
              wb_regw  <= ex_regw;
              wb_rd    <= ex_rd;
              wb_data  <= ex_alu_result;
            end else if (illegal_s) begin
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_exc   <= EXC_ILLEGAL;
            end else if (misalign_s) begin
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_exc   <= EXC_MISALIGN;
            end else begin
              state_r       <= ST_WAIT;
              wait_cnt_r    <= 8'd0;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= ex_memw;
              bus.mem_addr  <= {ex_alu_result[31:2], 2'b00};
              bus.mem_be    <= byte_enables(ex_funct3, ex_alu_result[1:0]);
              bus.mem_wdata <= store_data(ex_funct3, ex_rs2_data);
              cap_load_r    <= ex_memr;
              cap_regw_r    <= ex_regw;
              cap_mem2reg_r <= ex_mem2reg;
              cap_funct3_r  <= ex_funct3;
              cap_lane_r    <= ex_alu_result[1:0];
              cap_alu_r     <= ex_alu_result;
              cap_rd_r      <= ex_rd;
            end
          end
        end

        ST_WAIT: begin
          // If ready arrives on the last allowed cycle, the access completes
          // normally and no timeout is reported.
          if (bus.mem_ready) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 8'd0;
            bus.mem_req <= 1'b0;
            wb_valid    <= 1'b1;
            wb_rd       <= cap_rd_r;
            if (cap_load_r) begin
              wb_regw <= cap_regw_r;
              wb_data <= cap_mem2reg_r ? load_data_s : cap_alu_r;
            end
          end else if (wait_cnt_r == LAST_WAIT) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 8'd0;
            bus.mem_req <= 1'b0;
            wb_valid    <= 1'b1;
            wb_rd       <= cap_rd_r;
            wb_exc      <= EXC_TIMEOUT;
          end else begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          wait_cnt_r  <= 8'd0;
          bus.mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_stage
// Directed bench for lsu_mem_stage, instantiated with MAX_WAIT = 4.
// Each expected write-back bundle is queued when its instruction is driven.
// It is compared when the DUT pulses wb_valid.
// -----------------------------------------------------------------------------
module tb_lsu_mem_stage;

  typedef struct packed {
    logic        regw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  exc;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, flush, ex_memr, ex_memw, ex_mem2reg, ex_regw;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_result, ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        wb_valid, wb_regw;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_exc;

  int n_checks = 0;
  int n_fail   = 0;
  wb_t exp_q[$];

  lsu_mem_stage_if bus_if ();

  lsu_mem_stage #(.MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .flush         (flush),
    .ex_memr       (ex_memr),
    .ex_memw       (ex_memw),
    .ex_mem2reg    (ex_mem2reg),
    .ex_regw       (ex_regw),
    .ex_funct3     (ex_funct3),
    .ex_alu_result (ex_alu_result),
    .ex_rs2_data   (ex_rs2_data),
    .ex_rd         (ex_rd),
    .stall         (stall),
    .bus           (bus_if),
    .wb_valid      (wb_valid),
    .wb_regw       (wb_regw),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_exc        (wb_exc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, and score any wb pulse.
  task automatic tick();
    wb_t obs;
    wb_t exp;
    @(posedge clk);
    #1;
    if (wb_valid === 1'b1) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected: observed wb pulse rd %0d, expected no pulse", wb_rd);
      end
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        obs = {wb_regw, wb_rd, wb_data, wb_exc};
        check("sb_wb", 64'(obs), 64'(exp));
      end
    end
  endtask

  task automatic drive(input logic memr, input logic memw, input logic m2r, input logic regw,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [4:0] rd);
    ex_valid      = 1'b1;
    flush         = 1'b0;
    ex_memr       = memr;
    ex_memw       = memw;
    ex_mem2reg    = m2r;
    ex_regw       = regw;
    ex_funct3     = f3;
    ex_alu_result = addr;
    ex_rs2_data   = rs2;
    ex_rd         = rd;
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    flush         = 1'b0;
    ex_memr       = 1'b0;
    ex_memw       = 1'b0;
    ex_mem2reg    = 1'b0;
    ex_regw       = 1'b0;
    ex_funct3     = 3'b000;
    ex_alu_result = 32'h0000_0000;
    ex_rs2_data   = 32'h0000_0000;
    ex_rd         = 5'd0;
  endtask

  task automatic push(input logic regw, input logic [4:0] rd, input logic [31:0] data,
                      input logic [1:0] exc);
    wb_t e;
    e = {regw, rd, data, exc};
    exp_q.push_back(e);
  endtask

  initial begin
    int req_cycles;
    int stall_cycles;

    idle();
    bus_if.mem_ready = 1'b0;
    bus_if.mem_rdata = 32'h0000_0000;
    rst = 1'b1;
    tick();
    tick();
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_req", 64'(bus_if.mem_req), 64'd0);
    check("rst_we", 64'(bus_if.mem_we), 64'd0);
    check("rst_addr", 64'(bus_if.mem_addr), 64'd0);
    check("rst_be", 64'(bus_if.mem_be), 64'd0);
    check("rst_wdata", 64'(bus_if.mem_wdata), 64'd0);
    check("rst_wb", 64'({wb_valid, wb_regw, wb_rd, wb_data, wb_exc}), 64'd0);
    rst = 1'b0;
    tick();

    // LW 0x100, zero-wait memory
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd5);
    push(1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00);
    tick();
    idle();
    check("lw_req", 64'(bus_if.mem_req), 64'd1);
    check("lw_stall", 64'(stall), 64'd1);
    check("lw_we", 64'(bus_if.mem_we), 64'd0);
    check("lw_addr", 64'(bus_if.mem_addr), 64'h100);
    check("lw_be", 64'(bus_if.mem_be), 64'hF);
    bus_if.mem_ready = 1'b1;
    bus_if.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus_if.mem_ready = 1'b0;
    check("lw_wbv", 64'(wb_valid), 64'd1);
    check("lw_stall_low", 64'(stall), 64'd0);
    check("lw_req_low", 64'(bus_if.mem_req), 64'd0);

    // LB / LBU 0x103
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd6);
    push(1'b1, 5'd6, 32'hFFFF_FF80, 2'b00);
    tick();
    idle();
    check("lb_be", 64'(bus_if.mem_be), 64'h8);
    check("lb_addr", 64'(bus_if.mem_addr), 64'h100);
    bus_if.mem_ready = 1'b1;
    bus_if.mem_rdata = 32'h8012_3456;
    tick();
    bus_if.mem_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd6);
    push(1'b1, 5'd6, 32'h0000_0080, 2'b00);
    tick();
    idle();
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;

    // SH 0x22
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 5'd0);
    push(1'b0, 5'd0, 32'h0, 2'b00);
    tick();
    idle();
    check("sh_we", 64'(bus_if.mem_we), 64'd1);
    check("sh_addr", 64'(bus_if.mem_addr), 64'h20);
    check("sh_be", 64'(bus_if.mem_be), 64'hC);
    check("sh_wdata", 64'(bus_if.mem_wdata), 64'hABCD_ABCD);
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;

    // SB 0x11: byte replicated, lane 1
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0011, 32'h0000_00A5, 5'd0);
    push(1'b0, 5'd0, 32'h0, 2'b00);
    tick();
    idle();
    check("sb_be", 64'(bus_if.mem_be), 64'h2);
    check("sb_wdata", 64'(bus_if.mem_wdata), 64'hA5A5_A5A5);
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;

    // Faults: misaligned, illegal, illegal wins over misaligned
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0101, 32'h0, 5'd7);
    push(1'b0, 5'd7, 32'h0, 2'b01);
    tick();
    check("mis_req", 64'(bus_if.mem_req), 64'd0);
    check("mis_wbv", 64'(wb_valid), 64'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 5'd7);
    push(1'b0, 5'd7, 32'h0, 2'b11);
    tick();
    check("ill_req", 64'(bus_if.mem_req), 64'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 32'h0000_0103, 32'h0, 5'd8);
    push(1'b0, 5'd8, 32'h0, 2'b11);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 32'h0000_0100, 32'h0, 5'd1);
    push(1'b0, 5'd1, 32'h0, 2'b11);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b101, 32'h0000_0101, 32'h0, 5'd2);
    push(1'b0, 5'd2, 32'h0, 2'b01);
    tick();

    // LH 0x102: upper half, sign-extended
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 32'h0000_0102, 32'h0, 5'd3);
    push(1'b1, 5'd3, 32'hFFFF_8001, 2'b00);
    tick();
    idle();
    check("lh_be", 64'(bus_if.mem_be), 64'hC);
    bus_if.mem_ready = 1'b1;
    bus_if.mem_rdata = 32'h8001_7FFF;
    tick();
    bus_if.mem_ready = 1'b0;

    // Load with mem2reg = 0: writes back the ALU result
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0000_0048, 32'h0, 5'd11);
    push(1'b1, 5'd11, 32'h0000_0048, 2'b00);
    tick();
    idle();
    bus_if.mem_ready = 1'b1;
    tick();
    bus_if.mem_ready = 1'b0;

    // Non-memory ops, and a flushed op in IDLE
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'h0, 5'd2);
    push(1'b0, 5'd2, 32'h1234_5678, 2'b00);
    tick();
    check("alu_stall", 64'(stall), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0009, 32'h0, 5'd4);
    flush = 1'b1;
    tick();
    check("flush_wbv", 64'(wb_valid), 64'd0);
    idle();

    // Timeout: ready held low, so mem_req stays high for exactly MAX_WAIT cycles
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h0, 5'd3);
    push(1'b0, 5'd3, 32'h0, 2'b10);
    tick();
    idle();
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.mem_req === 1'b1) req_cycles++;
      tick();
    end
    check("to_req_cycles", 64'(req_cycles), 64'd4);

    // Ready arrives on the 4th WAIT cycle: normal completion
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0044, 32'h0, 5'd4);
    push(1'b1, 5'd4, 32'hCAFE_0001, 2'b00);
    tick();
    idle();
    tick();
    tick();
    tick();
    check("rdy4_req", 64'(bus_if.mem_req), 64'd1);
    bus_if.mem_ready = 1'b1;
    bus_if.mem_rdata = 32'hCAFE_0001;
    tick();
    bus_if.mem_ready = 1'b0;
    check("rdy4_req_low", 64'(bus_if.mem_req), 64'd0);

    // Back-to-back: a load with 3 wait cycles, then an ADD held during stall.
    // A flush during WAIT must not affect the outstanding load.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0080, 32'h0, 5'd8);
    push(1'b1, 5'd8, 32'h1111_2222, 2'b00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'd7, 32'h0, 5'd9);
    flush = 1'b1;
    stall_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (stall !== 1'b1) break;
      stall_cycles++;
      if (stall_cycles == 4) begin
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h1111_2222;
        flush = 1'b0;
        push(1'b1, 5'd9, 32'd7, 2'b00);
      end
      tick();
    end
    bus_if.mem_ready = 1'b0;
    check("b2b_stall_cycles", 64'(stall_cycles), 64'd4);
    check("b2b_lw_wbv", 64'(wb_valid), 64'd1);
    tick();
    idle();
    check("b2b_add_wbv", 64'(wb_valid), 64'd1);
    check("b2b_add_stall", 64'(stall), 64'd0);

    // Reset in the middle of WAIT abandons the access
    drive(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 32'h0000_0090, 32'h0, 5'd10);
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    check("rstw_req", 64'(bus_if.mem_req), 64'd0);
    check("rstw_stall", 64'(stall), 64'd0);
    check("rstw_wbv", 64'(wb_valid), 64'd0);
    rst = 1'b0;
    tick();
    tick();
    check("rstw_wbv_after", 64'(wb_valid), 64'd0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
